watch_time_set: RTL and testbench
=================================

WATCH_TIME_SET -- requirements
Module: watch_time_set

Interface
REQ-001 SHALL provide parameter DEFAULT_YEAR, default 12'd2000, year loaded into the shadow register at reset.
REQ-002 SHALL provide clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL provide rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide btn_mode  input  1  single-cycle pulse; enter edit / abort edit.
REQ-005 SHALL provide btn_next  input  1  single-cycle pulse; advance to next field / commit.
REQ-006 SHALL provide btn_inc  input  1  single-cycle pulse; increment selected field.
REQ-007 SHALL provide btn_dec  input  1  single-cycle pulse; decrement selected field.
REQ-008 SHALL provide cur_time  input  38  live time {year[11:0],month[3:0],day[4:0],hour[4:0],minute[5:0],second[5:0]} from the watch counter.
REQ-009 SHALL provide editing  output  1  high in any EDIT_* state.
REQ-010 SHALL provide field_sel  output  3  0=IDLE, 1=year, 2=month, 3=day, 4=hour, 5=minute, 6=second, 7=COMMIT.
REQ-011 SHALL provide set_time  output  1  single-cycle load strobe to the watch counter.
REQ-012 SHALL provide bin_time  output  38  shadow register, same packing as cur_time, driven continuously.

Function
REQ-013 SHALL implement states IDLE, EDIT_YEAR, EDIT_MONTH, EDIT_DAY, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT.
REQ-014 SHALL, on btn_mode in IDLE, capture cur_time into shadow and go to EDIT_YEAR next cycle; captured month 0 or >12 becomes 1, day 0 or >max becomes 1, hour >23 becomes 0, minute/second >59 become 0.
REQ-015 SHALL, on btn_next, advance EDIT_YEAR->MONTH->DAY->HOUR->MIN->SEC->COMMIT.
REQ-016 SHALL, on btn_mode in any EDIT_* state, return to IDLE without asserting set_time; shadow retains its value.
REQ-017 SHALL, in COMMIT, assert set_time for exactly one cycle and return to IDLE unconditionally; btn_next in EDIT_SEC at cycle N gives set_time high in cycle N+1.
REQ-018 SHALL apply input priority btn_mode > btn_next > btn_inc > btn_dec; only the highest asserted input acts per cycle.
REQ-019 SHALL wrap inc/dec per field: year 0..4095, month 1..12, day 1..max_day, hour 0..23, minute/second 0..59 (max+1 -> min, min-1 -> max).
REQ-020 SHALL compute max_day from shadow month and year: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; February per REQ-027/028.
REQ-021 SHALL, in the same cycle a month or year change lowers max_day below the shadow day, clamp day to the new max_day.
REQ-022 SHALL ignore btn_inc/btn_dec in IDLE and COMMIT; buttons in COMMIT are dropped.
REQ-023 SHALL leave set_time low in all states other than COMMIT.

Reset
REQ-024 SHALL, on rst low, asynchronously force state IDLE, set_time 0, editing 0, field_sel 0.
REQ-025 SHALL reset shadow to {DEFAULT_YEAR, 1, 1, 0, 0, 0}.
REQ-026 SHALL, on reset mid-edit or in COMMIT, abandon the edit with no set_time pulse after reset release.

Configuration
REQ-027 SHALL, with WATCH_LEAP_YEAR_EN defined, give February 29 days when year[1:0]==0, else 28.
REQ-028 SHALL, without WATCH_LEAP_YEAR_EN, give February 28 days always.

Structure
REQ-029 SHALL place field widths, the cur_time/bin_time bit offsets, the state encoding and the field_sel codes in shared package watch_pkg.
REQ-030 SHALL compute max_day in sub-module watch_days_in_month (inputs month, year; output 5-bit day count), reusable by the watch counter.

Verification
REQ-031 SHALL cover: cur_time=2023-06-15 10:20:30, mode, next x6 -> one set_time pulse, bin_time equal to captured value.
REQ-032 SHALL cover: EDIT_MIN at 59, inc -> minute 0; EDIT_HOUR at 0, dec -> hour 23; EDIT_YEAR at 4095, inc -> year 0.
REQ-033 SHALL cover: day 31, month 1 -> inc month to 2 -> day 28 (29 if WATCH_LEAP_YEAR_EN and year 2024).
REQ-034 SHALL cover: mode in EDIT_DAY -> IDLE, no set_time; btn_next and btn_inc same cycle -> field advance only.
REQ-035 SHALL cover: cur_time month 0, day 0, hour 31 captured -> shadow month 1, day 1, hour 0.
REQ-036 SHALL cover: rst asserted during EDIT_SEC -> IDLE, shadow {2000,1,1,0,0,0}, set_time never asserted.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared definitions for the watch time-setting logic: field widths, the
// bit layout of the packed time word, FSM state encoding and field_sel codes.
package watch_pkg;

    // Field widths of the packed time word
    localparam int YEAR_W  = 12;
    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;
    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;

    // Bit offsets inside cur_time / bin_time (second occupies the LSBs)
    localparam int SEC_LSB   = 0;
    localparam int MIN_LSB   = SEC_LSB + SEC_W;
    localparam int HOUR_LSB  = MIN_LSB + MIN_W;
    localparam int DAY_LSB   = HOUR_LSB + HOUR_W;
    localparam int MONTH_LSB = DAY_LSB + DAY_W;
    localparam int YEAR_LSB  = MONTH_LSB + MONTH_W;
    localparam int TIME_W    = YEAR_LSB + YEAR_W;

    // Field range limits
    localparam logic [MONTH_W-1:0] MONTH_MIN = 4'd1;
    localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd12;
    localparam logic [DAY_W-1:0]   DAY_MIN   = 5'd1;
    localparam logic [HOUR_W-1:0]  HOUR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0]   MIN_MAX   = 6'd59;
    localparam logic [SEC_W-1:0]   SEC_MAX   = 6'd59;

    // Packed time word; member order reproduces the cur_time/bin_time layout
    typedef struct packed {
        logic [YEAR_W-1:0]  year;
        logic [MONTH_W-1:0] month;
        logic [DAY_W-1:0]   day;
        logic [HOUR_W-1:0]  hour;
        logic [MIN_W-1:0]   minute;
        logic [SEC_W-1:0]   second;
    } watch_time_t;

    // field_sel output codes
    localparam logic [2:0] FSEL_IDLE   = 3'd0;
    localparam logic [2:0] FSEL_YEAR   = 3'd1;
    localparam logic [2:0] FSEL_MONTH  = 3'd2;
    localparam logic [2:0] FSEL_DAY    = 3'd3;
    localparam logic [2:0] FSEL_HOUR   = 3'd4;
    localparam logic [2:0] FSEL_MIN    = 3'd5;
    localparam logic [2:0] FSEL_SEC    = 3'd6;
    localparam logic [2:0] FSEL_COMMIT = 3'd7;

    // Editor FSM states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_EDIT_YEAR  = 3'd1,
        ST_EDIT_MONTH = 3'd2,
        ST_EDIT_DAY   = 3'd3,
        ST_EDIT_HOUR  = 3'd4,
        ST_EDIT_MIN   = 3'd5,
        ST_EDIT_SEC   = 3'd6,
        ST_COMMIT     = 3'd7
    } state_e;

    // Field selected in a given state
    function automatic logic [2:0] fsel_of(input state_e st);
        logic [2:0] code;
        code = FSEL_IDLE;
        case (st)
            ST_EDIT_YEAR:  code = FSEL_YEAR;
            ST_EDIT_MONTH: code = FSEL_MONTH;
            ST_EDIT_DAY:   code = FSEL_DAY;
            ST_EDIT_HOUR:  code = FSEL_HOUR;
            ST_EDIT_MIN:   code = FSEL_MIN;
            ST_EDIT_SEC:   code = FSEL_SEC;
            ST_COMMIT:     code = FSEL_COMMIT;
            default:       code = FSEL_IDLE;
        endcase
        return code;
    endfunction

    // Field order walked by btn_next; the last field leads to COMMIT
    function automatic state_e next_edit_state(input state_e st);
        state_e nxt;
        nxt = ST_IDLE;
        case (st)
            ST_EDIT_YEAR:  nxt = ST_EDIT_MONTH;
            ST_EDIT_MONTH: nxt = ST_EDIT_DAY;
            ST_EDIT_DAY:   nxt = ST_EDIT_HOUR;
            ST_EDIT_HOUR:  nxt = ST_EDIT_MIN;
            ST_EDIT_MIN:   nxt = ST_EDIT_SEC;
            ST_EDIT_SEC:   nxt = ST_COMMIT;
            default:       nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/watch_days_in_month.sv
// Number of days in a month. Purely combinational so the watch counter can
// reuse it. Build option: WATCH_LEAP_YEAR_EN gives February 29 days in years
// with year[1:0]==0; without it February always has 28 days.
// Out-of-range month codes report 31 so callers never see a zero day count.
module watch_days_in_month
    import watch_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic [YEAR_W-1:0]  year,
    output logic [DAY_W-1:0]   days
);

`ifdef WATCH_LEAP_YEAR_EN
    // Only the low two year bits decide a leap year
    logic unused_year_bits;
    assign unused_year_bits = ^year[YEAR_W-1:2];
`else
    logic unused_year_bits;
    assign unused_year_bits = ^year;
`endif

    // Month-length lookup
    always_comb begin
        days = 5'd31;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
`ifdef WATCH_LEAP_YEAR_EN
            4'd2:                    days = (year[1:0] == 2'd0) ? 5'd29 : 5'd28;
`else
            4'd2:                    days = 5'd28;
`endif
            default:                 days = 5'd31;
        endcase
    end

endmodule

// File: rtl/watch_time_set.sv
// Time-setting editor for the watch. btn_mode captures the live time into a
// shadow register, the user walks the fields with btn_next and adjusts them
// with btn_inc/btn_dec, and the final btn_next produces a one-cycle set_time
// strobe while bin_time holds the value to load.
// Build option: WATCH_LEAP_YEAR_EN (February length, see watch_days_in_month).
module watch_time_set
    import watch_pkg::*;
#(
    parameter logic [YEAR_W-1:0] DEFAULT_YEAR = 12'd2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_next,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic [TIME_W-1:0] cur_time,
    output logic              editing,
    output logic [2:0]        field_sel,
    output logic              set_time,
    output logic [TIME_W-1:0] bin_time
);

    localparam watch_time_t SHADOW_RST = '{
        year:   DEFAULT_YEAR,
        month:  MONTH_MIN,
        day:    DAY_MIN,
        hour:   '0,
        minute: '0,
        second: '0
    };

    state_e      state_q,  state_d;
    watch_time_t shadow_q, shadow_d;

    watch_time_t         cur;
    watch_time_t         cap_time;
    logic [MONTH_W-1:0]  cap_month;
    logic [DAY_W-1:0]    cap_max_day;

    logic [YEAR_W-1:0]   cand_year;
    logic [MONTH_W-1:0]  cand_month;
    logic [DAY_W-1:0]    cand_max_day;

    logic                in_edit;
    logic                act_inc;
    logic                act_dec;

    assign cur = cur_time;

    assign in_edit = (state_q != ST_IDLE) && (state_q != ST_COMMIT);

    // Buttons resolved by priority: inc/dec only act when nothing higher is pressed
    assign act_inc = in_edit & ~btn_mode & ~btn_next & btn_inc;
    assign act_dec = in_edit & ~btn_mode & ~btn_next & ~btn_inc & btn_dec;

    // Month is sanitised first because the day limit of the capture depends on it
    assign cap_month = ((cur.month == '0) || (cur.month > MONTH_MAX)) ? MONTH_MIN : cur.month;

    watch_days_in_month u_cap_days (
        .month (cap_month),
        .year  (cur.year),
        .days  (cap_max_day)
    );

    // Sanitised copy of the live time, loaded into the shadow when editing starts
    always_comb begin
        cap_time        = cur;
        cap_time.month  = cap_month;
        cap_time.day    = ((cur.day == '0) || (cur.day > cap_max_day)) ? DAY_MIN : cur.day;
        cap_time.hour   = (cur.hour   > HOUR_MAX) ? '0 : cur.hour;
        cap_time.minute = (cur.minute > MIN_MAX)  ? '0 : cur.minute;
        cap_time.second = (cur.second > SEC_MAX)  ? '0 : cur.second;
    end

    // Candidate year/month after this cycle's inc/dec; kept apart from the day
    // so the day limit can be derived from them without a combinational loop
    always_comb begin
        cand_year  = shadow_q.year;
        cand_month = shadow_q.month;
        if (state_q == ST_EDIT_YEAR) begin
            if (act_inc) begin
                cand_year = shadow_q.year + 12'd1;
            end else if (act_dec) begin
                cand_year = shadow_q.year - 12'd1;
            end
        end
        if (state_q == ST_EDIT_MONTH) begin
            if (act_inc) begin
                cand_month = (shadow_q.month >= MONTH_MAX) ? MONTH_MIN : shadow_q.month + 4'd1;
            end else if (act_dec) begin
                cand_month = (shadow_q.month <= MONTH_MIN) ? MONTH_MAX : shadow_q.month - 4'd1;
            end
        end
    end

    // Day limit for the candidate date; equals the current limit while editing the day
    watch_days_in_month u_cand_days (
        .month (cand_month),
        .year  (cand_year),
        .days  (cand_max_day)
    );

    // Next state and next shadow value
    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        shadow_d.year  = cand_year;
        shadow_d.month = cand_month;
        // A month/year change that shortens the month pulls the day down with it
        shadow_d.day   = (shadow_q.day > cand_max_day) ? cand_max_day : shadow_q.day;

        case (state_q)
            ST_IDLE: begin
                if (btn_mode) begin
                    state_d  = ST_EDIT_YEAR;
                    shadow_d = cap_time;
                end
            end

            ST_COMMIT: begin
                // Strobe lasts one cycle; any button pressed now is dropped
                state_d = ST_IDLE;
            end

            default: begin
                if (btn_mode) begin
                    state_d = ST_IDLE;
                end else if (btn_next) begin
                    state_d = next_edit_state(state_q);
                end else if (act_inc) begin
                    case (state_q)
                        ST_EDIT_DAY:
                            shadow_d.day = (shadow_q.day >= cand_max_day) ? DAY_MIN : shadow_q.day + 5'd1;
                        ST_EDIT_HOUR:
                            shadow_d.hour = (shadow_q.hour >= HOUR_MAX) ? '0 : shadow_q.hour + 5'd1;
                        ST_EDIT_MIN:
                            shadow_d.minute = (shadow_q.minute >= MIN_MAX) ? '0 : shadow_q.minute + 6'd1;
                        ST_EDIT_SEC:
                            shadow_d.second = (shadow_q.second >= SEC_MAX) ? '0 : shadow_q.second + 6'd1;
                        default: ;
                    endcase
                end else if (act_dec) begin
                    case (state_q)
                        ST_EDIT_DAY:
                            shadow_d.day = (shadow_q.day <= DAY_MIN) ? cand_max_day : shadow_q.day - 5'd1;
                        ST_EDIT_HOUR:
                            shadow_d.hour = (shadow_q.hour == '0) ? HOUR_MAX : shadow_q.hour - 5'd1;
                        ST_EDIT_MIN:
                            shadow_d.minute = (shadow_q.minute == '0) ? MIN_MAX : shadow_q.minute - 6'd1;
                        ST_EDIT_SEC:
                            shadow_d.second = (shadow_q.second == '0) ? SEC_MAX : shadow_q.second - 6'd1;
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // State and shadow registers; reset abandons any edit in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= SHADOW_RST;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
        end
    end

    assign editing   = in_edit;
    assign field_sel = fsel_of(state_q);
    assign set_time  = (state_q == ST_COMMIT);
    assign bin_time  = shadow_q;

endmodule

// File: tb/tb_watch_time_set.sv
// Directed bench for watch_time_set: capture/commit, field wrap-around,
// February day clamp, abort and button priority, capture sanitising and
// reset in the middle of an edit.
module tb_watch_time_set;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_mode = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic [37:0] cur_time = '0;
    logic        editing;
    logic [2:0]  field_sel;
    logic        set_time;
    logic [37:0] bin_time;

    int total = 0;
    int bad = 0;
    int set_cnt = 0;

`ifdef WATCH_LEAP_YEAR_EN
    localparam logic [4:0] FEB24 = 5'd29;
`else
    localparam logic [4:0] FEB24 = 5'd28;
`endif

    always #5 clk = ~clk;

    // Count every cycle in which the load strobe is seen
    always @(negedge clk) if (set_time === 1'b1) set_cnt++;

    watch_time_set dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_next  (btn_next),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .cur_time  (cur_time),
        .editing   (editing),
        .field_sel (field_sel),
        .set_time  (set_time),
        .bin_time  (bin_time)
    );

    function automatic logic [37:0] pk(input logic [11:0] y, input logic [3:0] m,
                                       input logic [4:0] d, input logic [4:0] h,
                                       input logic [5:0] mi, input logic [5:0] s);
        return {y, m, d, h, mi, s};
    endfunction

    // One-cycle button pulse; returns on the falling edge after the acting rising edge
    task automatic press(input logic m, input logic n, input logic i, input logic d);
        @(negedge clk);
        btn_mode = m; btn_next = n; btn_inc = i; btn_dec = d;
        @(negedge clk);
        btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        if (field_sel !== 3'd0) begin bad++; $display("FAIL reset_field_sel got=%0d want=0", field_sel); end
        total++;
        if (editing !== 1'b0) begin bad++; $display("FAIL reset_editing got=%b want=0", editing); end
        total++;
        if (set_time !== 1'b0) begin bad++; $display("FAIL reset_set_time got=%b want=0", set_time); end
        total++;
        if (bin_time !== pk(12'd2000, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0)) begin
            bad++; $display("FAIL reset_shadow got=%h want=%h", bin_time, pk(12'd2000, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0));
        end
        total++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset: field_sel=%0d bin_time=%h", field_sel, bin_time);
    endtask

    task automatic test_commit;
        logic [37:0] exp;
        int c0;
        exp = pk(12'd2023, 4'd6, 5'd15, 5'd10, 6'd20, 6'd30);
        cur_time = exp;
        #1 c0 = set_cnt;
        press(1, 0, 0, 0);
        if (field_sel !== 3'd1 || editing !== 1'b1) begin
            bad++; $display("FAIL commit_enter field_sel=%0d editing=%b want=1/1", field_sel, editing);
        end
        total++;
        if (bin_time !== exp) begin bad++; $display("FAIL commit_capture got=%h want=%h", bin_time, exp); end
        total++;
        repeat (5) press(0, 1, 0, 0);
        if (field_sel !== 3'd6 || set_time !== 1'b0) begin
            bad++; $display("FAIL commit_walk field_sel=%0d set_time=%b want=6/0", field_sel, set_time);
        end
        total++;
        press(0, 1, 0, 0);
        if (set_time !== 1'b1 || field_sel !== 3'd7 || editing !== 1'b0) begin
            bad++; $display("FAIL commit_strobe set_time=%b field_sel=%0d editing=%b want=1/7/0", set_time, field_sel, editing);
        end
        total++;
        @(negedge clk);
        if (set_time !== 1'b0 || field_sel !== 3'd0) begin
            bad++; $display("FAIL commit_return set_time=%b field_sel=%0d want=0/0", set_time, field_sel);
        end
        total++;
        repeat (3) @(negedge clk);
        #1;
        if (set_cnt - c0 !== 1) begin bad++; $display("FAIL commit_pulses got=%0d want=1", set_cnt - c0); end
        total++;
        if (bin_time !== exp) begin bad++; $display("FAIL commit_hold got=%h want=%h", bin_time, exp); end
        total++;
        $display("commit: bin_time=%h pulses=%0d", bin_time, set_cnt - c0);
    endtask

    task automatic test_wrap;
        logic [37:0] exp;
        cur_time = pk(12'd2023, 4'd6, 5'd15, 5'd0, 6'd59, 6'd30);
        press(1, 0, 0, 0);
        repeat (3) press(0, 1, 0, 0);
        if (field_sel !== 3'd4) begin bad++; $display("FAIL wrap_at_hour field_sel=%0d want=4", field_sel); end
        total++;
        press(0, 0, 0, 1);
        exp = pk(12'd2023, 4'd6, 5'd15, 5'd23, 6'd59, 6'd30);
        if (bin_time !== exp) begin bad++; $display("FAIL wrap_hour_dec got=%h want=%h", bin_time, exp); end
        total++;
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        exp = pk(12'd2023, 4'd6, 5'd15, 5'd23, 6'd0, 6'd30);
        if (bin_time !== exp) begin bad++; $display("FAIL wrap_min_inc got=%h want=%h", bin_time, exp); end
        total++;
        press(0, 0, 1, 0);
        exp = pk(12'd2023, 4'd6, 5'd15, 5'd23, 6'd1, 6'd30);
        if (bin_time !== exp) begin bad++; $display("FAIL min_inc got=%h want=%h", bin_time, exp); end
        total++;
        press(0, 1, 0, 0);
        press(0, 0, 0, 1);
        exp = pk(12'd2023, 4'd6, 5'd15, 5'd23, 6'd1, 6'd29);
        if (bin_time !== exp) begin bad++; $display("FAIL sec_dec got=%h want=%h", bin_time, exp); end
        total++;
        press(1, 0, 0, 0);
        $display("wrap time: bin_time=%h", bin_time);

        cur_time = pk(12'd4095, 4'd12, 5'd10, 5'd1, 6'd2, 6'd3);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        exp = pk(12'd0, 4'd12, 5'd10, 5'd1, 6'd2, 6'd3);
        if (bin_time !== exp) begin bad++; $display("FAIL wrap_year_inc got=%h want=%h", bin_time, exp); end
        total++;
        press(0, 0, 0, 1);
        exp = pk(12'd4095, 4'd12, 5'd10, 5'd1, 6'd2, 6'd3);
        if (bin_time !== exp) begin bad++; $display("FAIL wrap_year_dec got=%h want=%h", bin_time, exp); end
        total++;
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        exp = pk(12'd4095, 4'd1, 5'd10, 5'd1, 6'd2, 6'd3);
        if (bin_time !== exp) begin bad++; $display("FAIL wrap_month_inc got=%h want=%h", bin_time, exp); end
        total++;
        press(0, 0, 0, 1);
        exp = pk(12'd4095, 4'd12, 5'd10, 5'd1, 6'd2, 6'd3);
        if (bin_time !== exp) begin bad++; $display("FAIL wrap_month_dec got=%h want=%h", bin_time, exp); end
        total++;
        press(1, 0, 0, 0);
        $display("wrap date: bin_time=%h", bin_time);
    endtask

    task automatic test_clamp;
        logic [37:0] exp;
        cur_time = pk(12'd2024, 4'd1, 5'd31, 5'd8, 6'd0, 6'd0);
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        exp = pk(12'd2024, 4'd2, FEB24, 5'd8, 6'd0, 6'd0);
        if (bin_time !== exp) begin bad++; $display("FAIL clamp_month got=%h want=%h", bin_time, exp); end
        total++;
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        exp = pk(12'd2024, 4'd2, 5'd1, 5'd8, 6'd0, 6'd0);
        if (bin_time !== exp) begin bad++; $display("FAIL wrap_day_inc got=%h want=%h", bin_time, exp); end
        total++;
        press(0, 0, 0, 1);
        exp = pk(12'd2024, 4'd2, FEB24, 5'd8, 6'd0, 6'd0);
        if (bin_time !== exp) begin bad++; $display("FAIL wrap_day_dec got=%h want=%h", bin_time, exp); end
        total++;
        press(1, 0, 0, 0);
        // Leaving a leap year lowers the February limit to 28
        cur_time = pk(12'd2024, 4'd2, FEB24, 5'd8, 6'd0, 6'd0);
        press(1, 0, 0, 0);
        press(0, 0, 0, 1);
        exp = pk(12'd2023, 4'd2, 5'd28, 5'd8, 6'd0, 6'd0);
        if (bin_time !== exp) begin bad++; $display("FAIL clamp_year got=%h want=%h", bin_time, exp); end
        total++;
        press(1, 0, 0, 0);
        $display("clamp: bin_time=%h", bin_time);
    endtask

    task automatic test_abort_priority;
        logic [37:0] exp;
        int c0;
        cur_time = pk(12'd2022, 4'd7, 5'd4, 5'd12, 6'd30, 6'd45);
        #1 c0 = set_cnt;
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        exp = pk(12'd2022, 4'd7, 5'd5, 5'd12, 6'd30, 6'd45);
        if (field_sel !== 3'd0 || editing !== 1'b0 || set_time !== 1'b0) begin
            bad++; $display("FAIL abort_idle field_sel=%0d editing=%b set_time=%b want=0/0/0", field_sel, editing, set_time);
        end
        total++;
        if (bin_time !== exp) begin bad++; $display("FAIL abort_retain got=%h want=%h", bin_time, exp); end
        total++;
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        press(0, 0, 0, 1);
        if (field_sel !== 3'd0 || bin_time !== exp) begin
            bad++; $display("FAIL idle_ignore field_sel=%0d bin_time=%h want=0/%h", field_sel, bin_time, exp);
        end
        total++;
        press(1, 0, 0, 0);
        press(0, 1, 1, 0);
        exp = pk(12'd2022, 4'd7, 5'd4, 5'd12, 6'd30, 6'd45);
        if (field_sel !== 3'd2 || bin_time !== exp) begin
            bad++; $display("FAIL next_over_inc field_sel=%0d bin_time=%h want=2/%h", field_sel, bin_time, exp);
        end
        total++;
        press(0, 0, 1, 1);
        exp = pk(12'd2022, 4'd8, 5'd4, 5'd12, 6'd30, 6'd45);
        if (bin_time !== exp) begin bad++; $display("FAIL inc_over_dec got=%h want=%h", bin_time, exp); end
        total++;
        press(1, 1, 0, 0);
        if (field_sel !== 3'd0) begin bad++; $display("FAIL mode_over_next field_sel=%0d want=0", field_sel); end
        total++;
        repeat (3) @(negedge clk);
        #1;
        if (set_cnt !== c0) begin bad++; $display("FAIL abort_no_strobe got=%0d want=%0d", set_cnt, c0); end
        total++;
        $display("abort/priority: bin_time=%h", bin_time);
    endtask

    task automatic test_normalize;
        logic [37:0] exp;
        cur_time = {12'd2023, 4'd0, 5'd0, 5'd31, 6'd63, 6'd60};
        press(1, 0, 0, 0);
        exp = pk(12'd2023, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0);
        if (bin_time !== exp) begin bad++; $display("FAIL norm_zero got=%h want=%h", bin_time, exp); end
        total++;
        press(1, 0, 0, 0);
        cur_time = pk(12'd2023, 4'd4, 5'd31, 5'd23, 6'd59, 6'd59);
        press(1, 0, 0, 0);
        exp = pk(12'd2023, 4'd4, 5'd1, 5'd23, 6'd59, 6'd59);
        if (bin_time !== exp) begin bad++; $display("FAIL norm_day got=%h want=%h", bin_time, exp); end
        total++;
        press(1, 0, 0, 0);
        cur_time = pk(12'd2023, 4'd13, 5'd31, 5'd5, 6'd5, 6'd5);
        press(1, 0, 0, 0);
        exp = pk(12'd2023, 4'd1, 5'd31, 5'd5, 6'd5, 6'd5);
        if (bin_time !== exp) begin bad++; $display("FAIL norm_month got=%h want=%h", bin_time, exp); end
        total++;
        press(1, 0, 0, 0);
        $display("normalize: bin_time=%h", bin_time);
    endtask

    task automatic test_reset_mid_edit;
        logic [37:0] exp;
        int c0;
        exp = pk(12'd2000, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0);
        cur_time = pk(12'd2021, 4'd9, 5'd9, 5'd9, 6'd9, 6'd9);
        #1 c0 = set_cnt;
        press(1, 0, 0, 0);
        repeat (5) press(0, 1, 0, 0);
        if (field_sel !== 3'd6) begin bad++; $display("FAIL rst_mid_setup field_sel=%0d want=6", field_sel); end
        total++;
        #2 rst = 1'b0;
        #1;
        if (field_sel !== 3'd0 || editing !== 1'b0 || set_time !== 1'b0) begin
            bad++; $display("FAIL rst_mid_async field_sel=%0d editing=%b set_time=%b want=0/0/0", field_sel, editing, set_time);
        end
        total++;
        if (bin_time !== exp) begin bad++; $display("FAIL rst_mid_shadow got=%h want=%h", bin_time, exp); end
        total++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        if (set_cnt !== c0 || field_sel !== 3'd0) begin
            bad++; $display("FAIL rst_mid_after pulses=%0d field_sel=%0d want=%0d/0", set_cnt, field_sel, c0);
        end
        total++;
        $display("reset mid-edit: field_sel=%0d bin_time=%h", field_sel, bin_time);
    endtask

    initial begin
        test_reset();
        test_commit();
        test_wrap();
        test_clamp();
        test_abort_priority();
        test_normalize();
        test_reset_mid_edit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
